cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
Arbitrates the single external memory port between the I-cache refill path and the D-cache refill/write-back path.
- Grants one requester at a time.
- Sequences a full-line burst of LINE_WORDS single-word beats with a beat counter.
- Returns a one-cycle line-done pulse that the requesting cache controller uses as its mem_ready.
- Sits between both cache controllers and the memory interface.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
LINE_WORDS, 4, words per cache line (power of 2, >=2)
BEAT_W, 2, log2(LINE_WORDS)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
i_req  input  1  I-cache line fill request (I-cache mem_r)
i_addr  input  ADDR_W  I-cache miss address
i_rvalid  output  1  I-cache fill word valid this cycle
i_ready  output  1  I-cache line complete pulse
d_rd  input  1  D-cache line fill request
d_wr  input  1  D-cache line write-back request
d_addr  input  ADDR_W  D-cache line address
d_wdata  input  DATA_W  write-back word for current beat
d_rvalid  output  1  D-cache fill word valid / write word consumed
d_ready  output  1  D-cache transaction complete pulse
beat  output  BEAT_W  current word index within line
rdata  output  DATA_W  fill data to both caches (= m_rdata)
m_req  output  1  memory beat request
m_we  output  1  memory write enable
m_addr  output  ADDR_W  memory word address
m_wdata  output  DATA_W  memory write data
m_rdata  input  DATA_W  memory read data
m_ack  input  1  memory beat complete (read data valid / write accepted)

Behaviour:
- States: IDLE, I_FILL, D_FILL, D_WB, DONE. State register and beat counter reset to IDLE / 0; last_grant resets to I.
- All outputs are 0 in IDLE and while rst=1.
- IDLE arbitration, sampled each cycle:
  - D request = d_rd|d_wr. d_wr beats d_rd if both are high.
  - Only i_req -> I_FILL. Only D request -> D_WB (d_wr) or D_FILL (d_rd).
  - Both pending -> grant the requester not in last_grant (round-robin). After reset, D wins the first tie.
  - On grant: latch line base = addr with low (BEAT_W+2) bits zeroed, latch requester ID, set beat=0, update last_grant.
- Grant latency: m_req rises exactly one cycle after the request is first seen in IDLE.
- Transfer states:
  - m_req=1 continuously. m_addr = {base[ADDR_W-1:BEAT_W+2], beat, 2'b00}.
  - m_we=1 only in D_WB. m_wdata = d_wdata in D_WB, else 0.
  - m_ack is ignored unless m_req=1.
  - On m_ack: I_FILL -> i_rvalid=1 (combinational with m_ack); D_FILL/D_WB -> d_rvalid=1. beat increments on the following edge.
  - m_ack with beat==LINE_WORDS-1 -> DONE; beat wraps to 0.
- DONE, exactly one cycle:
  - i_ready=1 if the grant was I, else d_ready=1. m_req=0. No arbitration in this cycle.
  - Next state IDLE. The requester must drop its request by the cycle after DONE, and will since its controller moves on to STORE.
- Requests deasserted mid-burst are ignored; the burst completes the full line. A new request or an address change mid-burst has no effect.
- m_ack held high every cycle gives minimum total latency: request cycle 0, beats cycles 1..LINE_WORDS, DONE cycle LINE_WORDS+1, IDLE cycle LINE_WORDS+2.
- Write-back followed by fill (dirty eviction): two separate D transactions. The D-cache asserts d_rd after d_ready. An I request pending at the intervening IDLE wins by round-robin.
- rst asserted mid-burst: next edge -> IDLE, beat=0, m_req=0. A partial line is not signalled to either cache (no ready pulse).
- beat and rdata are shared. A cache uses them only when its own rvalid is high.

Test Plan:
1. i_req=1, i_addr=0x0000_1234, m_ack every cycle. Required: m_req from cycle 1; m_addr 0x1230,0x1234,0x1238,0x123C; i_rvalid cycles 1–4; i_ready only at cycle 5; d_* stay 0.
2. d_wr=1, d_addr=0x2000, d_wdata=0xA0+beat, m_ack every 2nd cycle. Required: m_we=1 throughout; m_wdata 0xA0..0xA3 per beat; beat held between acks; d_ready once after the 4th ack.
3. After reset, i_req and d_rd both rise in the same cycle. Required: D_FILL granted first, d_ready, then I_FILL starts the cycle after the next IDLE. A repeated tie later grants I first.
4. d_wr and d_rd both high, with i_req also high. Required: D_WB granted (last_grant=I); after DONE, I_FILL wins over the still-pending d_rd; then D_FILL.
5. During I_FILL, drop i_req after beat 1. Required: the burst continues to 4 beats and i_ready pulses once.
6. Assert rst at beat 2 of D_FILL. Required: next cycle m_req=0, beat=0, no d_ready; a post-reset i_req is served normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Purpose : shares one external memory port between the I-cache refill path and the
//           D-cache refill/write-back path, moving one full cache line per grant.
// Latency : m_req rises one cycle after a request is seen in IDLE; each beat completes on
//           m_ack; a one-cycle i_ready/d_ready pulse follows the last beat.
// Backpressure: memory stalls by withholding m_ack (beat and address hold); requests
//           arriving mid-burst wait for IDLE, where ties are settled round-robin.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   i_req/i_addr     - I-cache line fill request and miss address
//   i_rvalid/i_ready - I-cache fill word strobe / line complete pulse
//   d_rd/d_wr/d_addr - D-cache fill or write-back request and line address
//   d_wdata          - D-cache write-back word for the current beat
//   d_rvalid/d_ready - D-cache word strobe (fill or write consumed) / complete pulse
//   beat, rdata      - shared word index and fill data, valid with the owner's rvalid
//   m_*              - single-word memory port (req/we/addr/wdata/rdata/ack)
module cache_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int BEAT_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic              i_ready,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic              d_ready,
    output logic [BEAT_W-1:0] beat,
    output logic [DATA_W-1:0] rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    // Byte offset within a line: word index plus the two byte-select bits.
    localparam int OFF_W = BEAT_W + 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_FILL = 3'd1,
        D_FILL = 3'd2,
        D_WB   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [ADDR_W-OFF_W-1:0] base_q, base_d;     // line address without offset bits
    logic                    grant_d_q, grant_d_d; // current owner: 1 = D-cache
    logic                    last_d_q, last_d_d;   // previous owner: 1 = D-cache

    logic d_req;
    logic pick_d;
    logic busy;
    logic run;
    logic done;

    assign d_req = d_rd | d_wr;
    assign busy  = (state_q == I_FILL) || (state_q == D_FILL) || (state_q == D_WB);

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        grant_d_d = grant_d_q;
        last_d_d  = last_d_q;
        // On a tie the side that did not own the port last time wins.
        pick_d    = d_req && (!i_req || !last_d_q);
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    base_d    = pick_d ? d_addr[ADDR_W-1:OFF_W] : i_addr[ADDR_W-1:OFF_W];
                    grant_d_d = pick_d;
                    last_d_d  = pick_d;
                    beat_d    = '0;
                    if (!pick_d) begin
                        state_d = I_FILL;
                    end else if (d_wr) begin
                        state_d = D_WB;
                    end else begin
                        state_d = D_FILL;
                    end
                end
            end
            I_FILL, D_FILL, D_WB: begin
                if (m_ack) begin
                    // Counter wraps to 0 naturally after the last word.
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Requester drops its request during this cycle; no arbitration here.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            base_q    <= '0;
            grant_d_q <= 1'b0;
            last_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            grant_d_q <= grant_d_d;
            last_d_q  <= last_d_d;
        end
    end

    // Outputs decode the registered state; gating with rst keeps everything quiet
    // during a reset cycle even if the state register still holds a burst state.
    assign run  = busy && !rst;
    assign done = (state_q == DONE) && !rst;

    assign m_req    = run;
    assign m_we     = run && (state_q == D_WB);
    assign m_addr   = run ? {base_q, beat_q, 2'b00} : '0;
    assign m_wdata  = m_we ? d_wdata : '0;
    assign i_rvalid = run && m_ack && (state_q == I_FILL);
    assign d_rvalid = run && m_ack && ((state_q == D_FILL) || (state_q == D_WB));
    assign i_ready  = done && !grant_d_q;
    assign d_ready  = done && grant_d_q;
    assign beat     = run ? beat_q : '0;
    assign rdata    = run ? m_rdata : '0;

    // Low address bits select within the line and are replaced by the beat counter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Purpose : exercises cache_mem_arbiter with a table of request scenarios and a beat scoreboard.
// Latency : expected beats/completions queued at request time, retired as the DUT produces them.
// Backpressure: memory model acks every cycle or every Nth cycle to stall bursts.
module tb_cache_mem_arbiter;

    localparam logic [31:0] MEMX = 32'hDEAD_0000;
    localparam int K_I  = 1;
    localparam int K_DF = 2;
    localparam int K_DW = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_rvalid, i_ready;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata;
    logic        d_rvalid, d_ready;
    logic [1:0]  beat;
    logic [31:0] rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_ack = 1'b0;

    always #5 clk = ~clk;

    // Memory returns an address-derived word; the D-cache supplies 0xA0+beat on write-back.
    assign m_rdata = m_addr ^ MEMX;
    assign d_wdata = 32'h0000_00A0 + {30'd0, beat};

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_ready(i_ready),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_ready(d_ready),
        .beat(beat), .rdata(rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    typedef struct {
        int          kind;
        int          beat;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_cyc;
        bit          done;
    } sb_t;

    typedef struct {
        bit          do_rst;
        logic        i_req;
        logic        d_rd;
        logic        d_wr;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        int          gap;
        int          drop_k;
        int          n;
        int          o0;
        int          o1;
        int          o2;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[8];
    int   n_vec = 0;
    int   n_err = 0;
    int   gap = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ack_for(input int k);
        return (gap <= 1) ? 1'b1 : ((k % gap) == 1);
    endfunction

    task automatic push_txn(input int kind, input logic [31:0] addr, input int exp_cyc);
        sb_t e;
        for (int b = 0; b < 4; b++) begin
            e.kind    = kind;
            e.beat    = b;
            e.addr    = {addr[31:4], 4'h0} | (32'(b) << 2);
            e.wdata   = (kind == K_DW) ? 32'hA0 + 32'(b) : 32'h0;
            e.exp_cyc = -1;
            e.done    = 1'b0;
            sbq.push_back(e);
        end
        e.kind    = kind;
        e.beat    = 0;
        e.addr    = '0;
        e.wdata   = '0;
        e.exp_cyc = exp_cyc;
        e.done    = 1'b1;
        sbq.push_back(e);
    endtask

    // Called at the negedge of relative cycle k.
    task automatic monitor(input int k);
        sb_t e;
        if (m_req && m_ack) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("beat_not_done", e.done, 0);
                chk("i_rvalid", i_rvalid, e.kind == K_I);
                chk("d_rvalid", d_rvalid, e.kind != K_I);
                chk("m_we", m_we, e.kind == K_DW);
                chk("m_addr", m_addr, e.addr);
                chk("beat", beat, e.beat);
                chk("m_wdata", m_wdata, e.wdata);
                chk("rdata", rdata, e.addr ^ MEMX);
            end
        end else if (m_req) begin
            chk("stall_rvalid", {i_rvalid, d_rvalid}, 0);
            if (sbq.size() != 0) begin
                chk("stall_addr", m_addr, sbq[0].addr);
                chk("stall_beat", beat, sbq[0].beat);
            end
        end
        if (i_ready || d_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ready", {i_ready, d_ready}, 0);
            end else begin
                e = sbq.pop_front();
                chk("ready_is_done", e.done, 1);
                chk("i_ready", i_ready, e.kind == K_I);
                chk("d_ready", d_ready, e.kind != K_I);
                chk("done_mreq", m_req, 0);
                if (e.exp_cyc >= 0) chk("done_cycle", k, e.exp_cyc);
                // Requester moves on after its completion pulse.
                if (e.kind == K_I) i_req = 1'b0;
                else if (e.kind == K_DW) d_wr = 1'b0;
                else d_rd = 1'b0;
            end
        end
        if (!m_req && !i_ready && !d_ready) begin
            chk("quiet_ctl", {i_rvalid, d_rvalid, m_we, beat}, 0);
            chk("quiet_data", m_addr | m_wdata | rdata, 0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; m_ack = 1'b1;
        @(negedge clk);
        chk("rst_quiet", {m_req, i_ready, d_ready, i_rvalid, d_rvalid, beat}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int kind;
        if (v.do_rst) do_reset();
        @(posedge clk); #1;
        i_req = v.i_req; d_rd = v.d_rd; d_wr = v.d_wr;
        i_addr = v.i_addr; d_addr = v.d_addr;
        gap = v.gap;
        m_ack = ack_for(0);
        for (int t = 0; t < v.n; t++) begin
            kind = (t == 0) ? v.o0 : (t == 1) ? v.o1 : v.o2;
            push_txn(kind, (kind == K_I) ? v.i_addr : v.d_addr, (v.gap == 1) ? 5 + 6 * t : -1);
        end
        k = 0;
        forever begin
            @(negedge clk);
            if (k == 0) chk("idle_at_req", m_req, 0);
            if (k == 1) chk("grant_latency", m_req, 1);
            monitor(k);
            if (sbq.size() == 0) break;
            if (k >= 200) begin
                chk("timeout_left", 32'(sbq.size()), 0);
                sbq.delete();
                break;
            end
            @(posedge clk); #1;
            k++;
            m_ack = ack_for(k);
            if (k == v.drop_k) begin
                // Withdraw the request and scramble addresses mid-burst.
                i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
                i_addr = 32'hFFFF_FFF0; d_addr = 32'hFFFF_FFF0;
            end
        end
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after", m_req, 0);
    endtask

    initial begin
        //            rst i  dr dw i_addr          d_addr          gap drop n  o0    o1    o2
        tbl[0] = '{1'b1, 1, 0, 0, 32'h0000_1234, 32'h0,          1, -1, 1, K_I,  0,    0};
        tbl[1] = '{1'b0, 0, 0, 1, 32'h0,          32'h0000_2000, 2, -1, 1, K_DW, 0,    0};
        tbl[2] = '{1'b1, 1, 1, 0, 32'h0000_3000, 32'h0000_4010, 1, -1, 2, K_DF, K_I,  0};
        tbl[3] = '{1'b0, 0, 1, 0, 32'h0,          32'h0000_4020, 1, -1, 1, K_DF, 0,    0};
        tbl[4] = '{1'b0, 1, 1, 0, 32'h0000_3100, 32'h0000_4100, 1, -1, 2, K_I,  K_DF, 0};
        tbl[5] = '{1'b0, 1, 0, 0, 32'h0000_7004, 32'h0,          1,  2, 1, K_I,  0,    0};
        tbl[6] = '{1'b0, 1, 1, 1, 32'h0000_8000, 32'h0000_9000, 1, -1, 3, K_DW, K_I,  K_DF};
        tbl[7] = '{1'b0, 1, 0, 0, 32'h0000_6008, 32'h0,          1, -1, 1, K_I,  0,    0};

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Reset in the middle of a D fill: no completion pulse, port goes quiet.
        @(posedge clk); #1;
        gap = 1; m_ack = 1'b1; d_rd = 1'b1; d_addr = 32'h0000_5000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_beat0", {m_req, d_rvalid, beat}, {1'b1, 1'b1, 2'd0});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_beat1", {m_req, d_rvalid, beat}, {1'b1, 1'b1, 2'd1});
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_quiet", {m_req, d_rvalid, d_ready, beat}, 0);
        @(posedge clk); #1;
        rst = 1'b0; d_rd = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstmid_no_ready", {m_req, d_ready, i_ready, beat}, 0);
            @(posedge clk); #1;
        end

        // Normal service after the aborted burst.
        run_vec(tbl[7]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
